accumulator_drain: RTL

ACCUMULATOR_DRAIN -- requirements
Module: accumulator_drain

---
 rtl/acc_pkg.sv | 11 +
 rtl/acc_requant.sv | 27 ++
 rtl/accumulator_drain.sv | 136 +++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared accumulator geometry and drain FSM state encoding.
package acc_pkg;
    localparam int ACC_ROWS = 256;
    localparam int ACC_COLS = 3;
    localparam int ACC_W    = 32;
    localparam int Q_W      = 8;
    localparam int ADDR_W   = $clog2(ACC_ROWS);
    localparam int CNT_W    = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, SETUP, RUN, FLUSH, DONE} drain_state_t;
endpackage

// File: rtl/acc_requant.sv
// One-column requantizer: optional ReLU, rounding arithmetic right shift, int8 saturation.
module acc_requant
    import acc_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic             relu_en_i,
    input  logic [4:0]       shift_i,
    output logic [Q_W-1:0]   q_o
);
    localparam logic signed [ACC_W:0] ONE  = 1;
    localparam logic signed [ACC_W:0] QMAX = 2**(Q_W-1) - 1;
    localparam logic signed [ACC_W:0] QMIN = -(2**(Q_W-1));

    logic signed [ACC_W:0] ext, rnd, shf;

    always_comb begin
        // One extra bit so the rounding add cannot wrap near INT32_MAX.
        ext = {acc_i[ACC_W-1], acc_i};
        rnd = ext;
        if (shift_i != 5'd0) rnd = ext + (ONE <<< (shift_i - 5'd1));
        shf = rnd >>> shift_i;
        if (relu_en_i && acc_i[ACC_W-1]) q_o = '0;
        else if (shf > QMAX)             q_o = {1'b0, {(Q_W-1){1'b1}}};
        else if (shf < QMIN)             q_o = {1'b1, {(Q_W-1){1'b0}}};
        else                             q_o = shf[Q_W-1:0];
    end
endmodule

// File: rtl/accumulator_drain.sv
// Drains accumulator rows through per-column requantizers into a small output FIFO
// with ready/valid backpressure; reads are throttled so the FIFO never overflows.
module accumulator_drain
    import acc_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      buf_sel,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          row_count,
    input  logic                      relu_en,
    input  logic [4:0]                shift,
    output logic                      busy,
    output logic                      done,
    output logic                      acc_buf_sel,
    output logic                      acc_rd_en,
    output logic [ADDR_W-1:0]         acc_rd_addr,
    input  logic [ACC_COLS*ACC_W-1:0] acc_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_COLS*Q_W-1:0]   out_data,
    output logic                      out_last
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    drain_state_t              state_q, state_d;
    logic                      buf_sel_q, relu_q;
    logic [ADDR_W-1:0]         base_q;
    logic [CNT_W-1:0]          count_q, rd_cnt_q, rd_cnt_d;
    logic [4:0]                shift_q;
    logic                      inflight_q, inflight_last_q;
    logic                      rd_en, rd_last, push, pop;
    logic [OW-1:0]             occ;
    logic [ACC_COLS*Q_W-1:0]   q_row;
    logic [ACC_COLS*Q_W-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     last_mem_q;
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             fifo_cnt_q;

    for (genvar c = 0; c < ACC_COLS; c++) begin : g_col
        acc_requant u_rq (
            .acc_i     (acc_rd_data[c*ACC_W +: ACC_W]),
            .relu_en_i (relu_q),
            .shift_i   (shift_q),
            .q_o       (q_row[c*Q_W +: Q_W])
        );
    end

    assign push = inflight_q;
    assign pop  = out_valid & out_ready;
    // Rows that will be held after this cycle: stored + arriving - leaving.
    assign occ  = {1'b0, fifo_cnt_q} + OW'(inflight_q) - OW'(pop);

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rd_en    = 1'b0;
        rd_last  = 1'b0;
        unique case (state_q)
            IDLE:  if (start) begin
                       state_d  = SETUP;
                       rd_cnt_d = '0;
                   end
            SETUP: state_d = (count_q == '0) ? DONE : RUN;
            RUN:   if (occ < OW'(FIFO_DEPTH)) begin
                       rd_en    = 1'b1;
                       rd_last  = (rd_cnt_q == count_q - CNT_W'(1));
                       rd_cnt_d = rd_cnt_q + CNT_W'(1);
                       if (rd_last) state_d = FLUSH;
                   end
            // Leave as the final row is popped so done follows that transfer directly.
            FLUSH: if (!inflight_q && occ == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_sel_q       <= 1'b0;
            relu_q          <= 1'b0;
            base_q          <= '0;
            count_q         <= '0;
            shift_q         <= '0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_last;
            if (state_q == IDLE && start) begin
                buf_sel_q <= buf_sel;
                relu_q    <= relu_en;
                base_q    <= base_addr;
                count_q   <= row_count;
                shift_q   <= shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]      <= q_row;
            last_mem_q[wr_ptr_q] <= inflight_last_q;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign acc_buf_sel = buf_sel_q;
    assign acc_rd_en   = rd_en;
    assign acc_rd_addr = rd_en ? base_q + rd_cnt_q[ADDR_W-1:0] : '0;
    assign out_valid   = (fifo_cnt_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_last    = out_valid & last_mem_q[rd_ptr_q];
endmodule
